// File: rtl/midori_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : midori_ctrl_pkg                                         |
// | Description: Shared constants and FSM encoding for the Midori64      |
// |              masked S-box layer controller.                          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package midori_ctrl_pkg;

   localparam int NBYTES  = 8;                // byte-passes per layer
   localparam int LAT     = 3;                // sb_in update -> sb_out capture, in edges
   localparam int RND_W   = 90;               // fresh randomness bits per pass
   localparam int IDX_W   = $clog2(NBYTES);   // byte index width
   localparam int STATE_W = 8 * NBYTES;       // width of one share

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/midori_sbox_layer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface  : midori_sbox_layer_ctrl_if                               |
// | Description: PRNG valid/ready channel plus the share/randomness bus  |
// |              to and from the external 2-nibble masked S-box.         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface midori_sbox_layer_ctrl_if;
   import midori_ctrl_pkg::*;

   logic [RND_W-1:0] rnd_i;
   logic             rnd_valid_i;
   logic             rnd_ready_o;
   logic [7:0]       sb_in1_o;
   logic [7:0]       sb_in2_o;
   logic [7:0]       sb_in3_o;
   logic [RND_W-1:0] sb_r_o;
   logic [7:0]       sb_out1_i;
   logic [7:0]       sb_out2_i;
   logic [7:0]       sb_out3_i;

   // Controller side
   modport master (
      input  rnd_i, rnd_valid_i, sb_out1_i, sb_out2_i, sb_out3_i,
      output rnd_ready_o, sb_in1_o, sb_in2_o, sb_in3_o, sb_r_o
   );

   // PRNG and S-box side
   modport slave (
      output rnd_i, rnd_valid_i, sb_out1_i, sb_out2_i, sb_out3_i,
      input  rnd_ready_o, sb_in1_o, sb_in2_o, sb_in3_o, sb_r_o
   );
endinterface
`default_nettype wire

// File: rtl/sbox_pipe_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : sbox_pipe_tracker                                       |
// | Description: DEPTH-deep shift register of {valid, byte index} that   |
// |              mirrors the passes travelling through the S-box.        |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module sbox_pipe_tracker #(
   parameter int DEPTH = 3,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             push_valid_i,
   input  logic [IDX_W-1:0] push_idx_i,
   output logic             tail_valid_o,
   output logic [IDX_W-1:0] tail_idx_o,
   output logic             empty_o
);

   logic             valid_q [DEPTH];
   logic [IDX_W-1:0] idx_q   [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         // Head stage takes the pass issued on this edge (or a bubble)
         always_ff @(posedge clk) begin
            if (rst_i) begin
               valid_q[0] <= 1'b0;
               idx_q[0]   <= '0;
            end else begin
               valid_q[0] <= push_valid_i;
               idx_q[0]   <= push_idx_i;
            end
         end
      end else begin : g_body
         // Later stages advance one slot per edge, bubbles included
         always_ff @(posedge clk) begin
            if (rst_i) begin
               valid_q[g] <= 1'b0;
               idx_q[g]   <= '0;
            end else begin
               valid_q[g] <= valid_q[g-1];
               idx_q[g]   <= idx_q[g-1];
            end
         end
      end
   end

   assign tail_valid_o = valid_q[DEPTH-1];
   assign tail_idx_o   = idx_q[DEPTH-1];

   // Tracker is empty when no stage holds a live pass
   always_comb begin
      empty_o = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) empty_o = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/midori_sbox_layer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : midori_sbox_layer_ctrl                                  |
// | Description: Sequences one Midori64 S-box layer (3 shares) through a |
// |              shared 2-nibble masked S-box, one byte per pass, and    |
// |              reassembles the masked result. Shares stay separate.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module midori_sbox_layer_ctrl
   import midori_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [STATE_W-1:0] state1_i,
   input  logic [STATE_W-1:0] state2_i,
   input  logic [STATE_W-1:0] state3_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [STATE_W-1:0] state1_o,
   output logic [STATE_W-1:0] state2_o,
   output logic [STATE_W-1:0] state3_o,
   midori_sbox_layer_ctrl_if.master bus
);

   ctrl_state_e        state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [STATE_W-1:0] sh1_q, sh2_q, sh3_q;
   logic [STATE_W-1:0] res1_q, res2_q, res3_q;
   logic [7:0]         sb_in1_q, sb_in2_q, sb_in3_q;
   logic [RND_W-1:0]   sb_r_q;

   logic               push_vld_d;
   logic [IDX_W-1:0]   push_idx_d;
   logic               tail_vld;
   logic [IDX_W-1:0]   tail_idx;
   logic               trk_empty;
   logic               last_cap;

   // A pass is issued on every RUN cycle that receives fresh randomness
   assign push_vld_d = (state_q == RUN) && bus.rnd_valid_i;
   assign push_idx_d = ptr_q;

   sbox_pipe_tracker #(
      .DEPTH (LAT),
      .IDX_W (IDX_W)
   ) u_tracker (
      .clk          (clk),
      .rst_i        (rst_i),
      .push_valid_i (push_vld_d),
      .push_idx_i   (push_idx_d),
      .tail_valid_o (tail_vld),
      .tail_idx_o   (tail_idx),
      .empty_o      (trk_empty)
   );

   assign last_cap = tail_vld && (tail_idx == IDX_W'(NBYTES - 1));

   // Layer sequencer: latch shares, issue byte-passes in order, wait for the last capture
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         sh1_q    <= '0;
         sh2_q    <= '0;
         sh3_q    <= '0;
         sb_in1_q <= '0;
         sb_in2_q <= '0;
         sb_in3_q <= '0;
         sb_r_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && trk_empty) begin
                  sh1_q   <= state1_i;
                  sh2_q   <= state2_i;
                  sh3_q   <= state3_i;
                  ptr_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (bus.rnd_valid_i) begin
                  sb_in1_q <= sh1_q[{ptr_q, 3'b000} +: 8];
                  sb_in2_q <= sh2_q[{ptr_q, 3'b000} +: 8];
                  sb_in3_q <= sh3_q[{ptr_q, 3'b000} +: 8];
                  sb_r_q   <= bus.rnd_i;
                  ptr_q    <= ptr_q + IDX_W'(1);
                  if (ptr_q == IDX_W'(NBYTES - 1)) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_cap) state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Write each S-box result byte back into its slot as it leaves the pipeline
   always_ff @(posedge clk) begin
      if (rst_i) begin
         res1_q <= '0;
         res2_q <= '0;
         res3_q <= '0;
      end else if (tail_vld) begin
         res1_q[{tail_idx, 3'b000} +: 8] <= bus.sb_out1_i;
         res2_q[{tail_idx, 3'b000} +: 8] <= bus.sb_out2_i;
         res3_q[{tail_idx, 3'b000} +: 8] <= bus.sb_out3_i;
      end
   end

   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == DONE);
   assign state1_o        = res1_q;
   assign state2_o        = res2_q;
   assign state3_o        = res3_q;
   assign bus.rnd_ready_o = (state_q == RUN);
   assign bus.sb_in1_o    = sb_in1_q;
   assign bus.sb_in2_o    = sb_in2_q;
   assign bus.sb_in3_o    = sb_in3_q;
   assign bus.sb_r_o      = sb_r_q;

endmodule
`default_nettype wire
